// File: rtl/keypad_code_check_if.sv
// Keypad code-check bus.
//   master : driven by the keypad scan/control side (key_in, clear, secret),
//            observes the checker status (digit_cnt, unlock, fail, timeout, locked)
//   slave  : the code checker itself
// Ports carried:
//   key_in    [2:0]            key code, nonzero = one key pulse this cycle
//   clear                      synchronous abort of the current entry
//   secret    [3*CODE_LEN-1:0] code, first digit in the top 3 bits
//   digit_cnt [CNT_W-1:0]      digits currently held
//   unlock / fail / timeout    1-cycle result pulses
//   locked                     lockout level
interface keypad_code_check_if #(
  parameter int CODE_LEN = 4
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);

  logic [2:0]            key_in;
  logic                  clear;
  logic [3*CODE_LEN-1:0] secret;
  logic [CNT_W-1:0]      digit_cnt;
  logic                  unlock;
  logic                  fail;
  logic                  timeout;
  logic                  locked;

  modport master (
    output key_in,
    output clear,
    output secret,
    input  digit_cnt,
    input  unlock,
    input  fail,
    input  timeout,
    input  locked
  );

  modport slave (
    input  key_in,
    input  clear,
    input  secret,
    output digit_cnt,
    output unlock,
    output fail,
    output timeout,
    output locked
  );
endinterface

// File: rtl/keypad_code_check.sv
// Keypad code checker.
// Assembles single-cycle key pulses into a CODE_LEN-digit entry (3 bits per
// digit, first key in the top slot), compares the completed entry against
// the secret and reports the result as registered pulses. MAX_FAILS
// consecutive mismatches force a LOCKOUT-cycle lockout during which keys and
// clear are ignored. Inactivity of TIMEOUT cycles mid-entry aborts the entry.
// Ports:
//   clk   system clock, rising edge
//   nrst  asynchronous active-low reset
//   bus   keypad_code_check_if.slave (key_in, clear, secret in;
//         digit_cnt, unlock, fail, timeout, locked out)
module keypad_code_check #(
  parameter int CODE_LEN  = 4,
  parameter int TIMEOUT   = 1000,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT   = 5000
) (
  input  logic               clk,
  input  logic               nrst,
  keypad_code_check_if.slave bus
);

  localparam int BUF_W = 3 * CODE_LEN;
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int LK_W  = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    CHECK,
    LOCK
  } state_t;

  state_t           state;
  logic [BUF_W-1:0] buffer;
  logic [CNT_W-1:0] digit_cnt;
  logic [TMR_W-1:0] timer;
  logic [FC_W-1:0]  fail_cnt;
  logic [LK_W-1:0]  lock_timer;
  logic             unlock_q;
  logic             fail_q;
  logic             timeout_q;
  logic             locked_q;

  logic             key_hit;
  logic [BUF_W-1:0] key_ext;
  logic [BUF_W-1:0] buf_shift;
  logic             last_digit;
  logic             last_fail;

  // Key zero-extended to buffer width; works for CODE_LEN=1 without a
  // zero-width slice.
  always_comb begin
    key_ext      = '0;
    key_ext[2:0] = bus.key_in;
  end

  assign key_hit    = (bus.key_in != 3'd0);
  assign buf_shift  = (buffer << 3) | key_ext;
  assign last_digit = (digit_cnt == CNT_W'(CODE_LEN - 1));
  assign last_fail  = ((fail_cnt + FC_W'(1)) == FC_W'(MAX_FAILS));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      buffer     <= '0;
      digit_cnt  <= '0;
      timer      <= '0;
      fail_cnt   <= '0;
      lock_timer <= '0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      unlock_q  <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.clear) begin
            buffer    <= '0;
            digit_cnt <= '0;
            timer     <= '0;
          end else if (key_hit) begin
            buffer    <= key_ext;
            digit_cnt <= CNT_W'(1);
            timer     <= '0;
            state     <= (CODE_LEN == 1) ? CHECK : ENTRY;
          end
        end

        ENTRY: begin
          if (bus.clear) begin
            buffer    <= '0;
            digit_cnt <= '0;
            timer     <= '0;
            state     <= IDLE;
          end else if (key_hit) begin
            buffer    <= buf_shift;
            digit_cnt <= digit_cnt + CNT_W'(1);
            timer     <= '0;
            if (last_digit) begin
              state <= CHECK;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            buffer    <= '0;
            digit_cnt <= '0;
            timer     <= '0;
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // Single evaluation cycle: key_in and clear are not looked at here.
        CHECK: begin
          buffer    <= '0;
          digit_cnt <= '0;
          timer     <= '0;
          if (buffer == bus.secret) begin
            unlock_q <= 1'b1;
            fail_cnt <= '0;
            state    <= IDLE;
          end else begin
            fail_q   <= 1'b1;
            fail_cnt <= fail_cnt + FC_W'(1);
            if (last_fail) begin
              locked_q   <= 1'b1;
              lock_timer <= '0;
              state      <= LOCK;
            end else begin
              state <= IDLE;
            end
          end
        end

        LOCK: begin
          if (lock_timer == LK_W'(LOCKOUT - 1)) begin
            locked_q   <= 1'b0;
            fail_cnt   <= '0;
            lock_timer <= '0;
            state      <= IDLE;
          end else begin
            lock_timer <= lock_timer + LK_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.digit_cnt = digit_cnt;
  assign bus.unlock    = unlock_q;
  assign bus.fail      = fail_q;
  assign bus.timeout   = timeout_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_keypad_code_check.sv
// Self-checking bench for keypad_code_check: directed scenarios followed by
// randomized key traffic, all compared every cycle against a queue-based
// reference model of the entry/check/lockout rules.
module tb_keypad_code_check;

  localparam int CODE_LEN  = 4;
  localparam int TIMEOUT   = 16;
  localparam int MAX_FAILS = 3;
  localparam int LOCKOUT   = 32;
  localparam int CNT_W     = $clog2(CODE_LEN + 1);

  logic clk;
  logic nrst;

  keypad_code_check_if #(.CODE_LEN(CODE_LEN)) bus ();

  keypad_code_check #(
    .CODE_LEN (CODE_LEN),
    .TIMEOUT  (TIMEOUT),
    .MAX_FAILS(MAX_FAILS),
    .LOCKOUT  (LOCKOUT)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int q[$];          // digits entered so far, oldest first
  int idle_cnt;      // cycles since last key while an entry is open
  int fails;         // consecutive failed attempts
  int lock_left;     // remaining lockout cycles
  bit check_pend;    // entry complete, result due on the next edge
  int e_cnt;
  bit e_unlock, e_fail, e_timeout, e_locked;

  function automatic int pack_code();
    int code = 0;
    foreach (q[i]) code = code * 8 + q[i];
    return code;
  endfunction

  task automatic model_reset();
    q.delete();
    idle_cnt = 0; fails = 0; lock_left = 0; check_pend = 0;
    e_cnt = 0; e_unlock = 0; e_fail = 0; e_timeout = 0; e_locked = 0;
  endtask

  task automatic model_step(input int k, input bit c, input int sec);
    e_unlock = 0; e_fail = 0; e_timeout = 0;
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end else if (check_pend) begin
      check_pend = 0;
      if (pack_code() == sec) begin
        e_unlock = 1;
        fails = 0;
      end else begin
        e_fail = 1;
        fails++;
        if (fails == MAX_FAILS) lock_left = LOCKOUT;
      end
      q.delete();
      idle_cnt = 0;
    end else if (c) begin
      q.delete();
      idle_cnt = 0;
    end else if (k != 0) begin
      q.push_back(k);
      idle_cnt = 0;
      if (q.size() == CODE_LEN) check_pend = 1;
    end else if (q.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT) begin
        e_timeout = 1;
        q.delete();
        idle_cnt = 0;
      end
    end
    e_cnt = q.size();
    e_locked = (lock_left > 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic compare_all();
    check_val("digit_cnt", 32'(bus.digit_cnt), 32'(e_cnt));
    check_val("unlock",    32'(bus.unlock),    32'(e_unlock));
    check_val("fail",      32'(bus.fail),      32'(e_fail));
    check_val("timeout",   32'(bus.timeout),   32'(e_timeout));
    check_val("locked",    32'(bus.locked),    32'(e_locked));
  endtask

  task automatic step(input int k, input bit c);
    bus.key_in = 3'(k);
    bus.clear  = c;
    @(posedge clk);
    model_step(k, c, int'(bus.secret));
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0);
  endtask

  task automatic enter(input int d0, input int d1, input int d2, input int d3, input int gap);
    step(d0, 1'b0); idle(gap);
    step(d1, 1'b0); idle(gap);
    step(d2, 1'b0); idle(gap);
    step(d3, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2;
    nrst = 1'b0;
    #1;
    check_val({tag, "_cnt"},     32'(bus.digit_cnt), 32'd0);
    check_val({tag, "_unlock"},  32'(bus.unlock),    32'd0);
    check_val({tag, "_fail"},    32'(bus.fail),      32'd0);
    check_val({tag, "_timeout"}, 32'(bus.timeout),   32'd0);
    check_val({tag, "_locked"},  32'(bus.locked),    32'd0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  int kp;
  int d;
  int sec_digits[CODE_LEN];
  int unlock_seen, fail_seen, timeout_seen, lock_seen;

  always @(negedge clk) begin
    if (nrst) begin
      if (bus.unlock)  unlock_seen++;
      if (bus.fail)    fail_seen++;
      if (bus.timeout) timeout_seen++;
      if (bus.locked)  lock_seen++;
    end
  end

  initial begin
    unlock_seen = 0; fail_seen = 0; timeout_seen = 0; lock_seen = 0;
    nrst       = 1'b0;
    bus.key_in = 3'd0;
    bus.clear  = 1'b0;
    bus.secret = {3'd1, 3'd2, 3'd3, 3'd4};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    nrst = 1'b1;

    // 1: spaced correct entry
    enter(1, 2, 3, 4, 2);
    idle(4);

    // 2: three mismatches, lockout, keys ignored while locked, then unlock
    for (int n = 0; n < 3; n++) begin
      enter(1, 2, 3, 5, 0);
      idle(3);
    end
    for (int i = 0; i < 36; i++) step((i % 3 == 0) ? 1 + (i % 7) : 0, (i % 5 == 0));
    enter(1, 2, 3, 4, 0);
    idle(3);

    // 3: inactivity timeout, then correct entry
    step(1, 1'b0); step(2, 1'b0);
    idle(TIMEOUT + 2);
    enter(1, 2, 3, 4, 1);
    idle(3);

    // 4: key during the CHECK cycle is dropped
    enter(1, 2, 3, 4, 0);
    step(7, 1'b0);
    idle(3);

    // 5: clear beats a same-cycle key; two fails then a match leaves no lockout
    step(1, 1'b0); step(2, 1'b0); step(3, 1'b1);
    idle(3);
    enter(1, 2, 3, 6, 0); idle(2);
    enter(7, 7, 7, 7, 0); idle(2);
    enter(1, 2, 3, 4, 0); idle(2);
    enter(1, 1, 1, 1, 0); idle(2);
    enter(2, 2, 2, 2, 0); idle(2);
    enter(1, 2, 3, 4, 0); idle(2);

    // 6: reset mid-entry and mid-lockout
    step(1, 1'b0); step(2, 1'b0);
    async_reset("rst_entry");
    for (int n = 0; n < 3; n++) begin
      enter(4, 3, 2, 1, 0);
      idle(2);
    end
    idle(5);
    async_reset("rst_lock");
    enter(1, 2, 3, 4, 0);
    idle(3);

    // Randomized traffic with occasional secret changes
    for (int i = 0; i < CODE_LEN; i++) sec_digits[i] = i + 1;
    kp = 30;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: kp = 5;
          1: kp = 35;
          default: kp = 80;
        endcase
      end
      if (cyc % 300 == 150) begin
        for (int i = 0; i < CODE_LEN; i++) sec_digits[i] = $urandom_range(0, 7);
        bus.secret = {3'(sec_digits[0]), 3'(sec_digits[1]), 3'(sec_digits[2]), 3'(sec_digits[3])};
      end
      d = 0;
      if ($urandom_range(0, 99) < kp) begin
        if ($urandom_range(0, 99) < 70 && q.size() < CODE_LEN && sec_digits[q.size()] != 0)
          d = sec_digits[q.size()];
        else
          d = $urandom_range(1, 7);
      end
      step(d, ($urandom_range(0, 99) < 2));
    end
    idle(4);

    // Coverage sanity: every kind of event must have occurred.
    check_val("unlock_seen",  32'(unlock_seen  > 0), 32'd1);
    check_val("fail_seen",    32'(fail_seen    > 0), 32'd1);
    check_val("timeout_seen", 32'(timeout_seen > 0), 32'd1);
    check_val("lock_seen",    32'(lock_seen    > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
